path_trace: RTL and testbench
=============================

PATH_TRACE -- requirements
Module: path_trace

Interface
REQ-001 Parameters: SIZE_ROW, default 4, grid columns per row; MAX, default 8192, total cells in the P memory; D_WIDTH, default 8, P data width; A_WIDTH, default 13, P address width.
REQ-002 Clk  in  1  single clock; all state changes on rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-low.
REQ-004 Go  in  1  start pulse; sampled only in IDLE.
REQ-005 End_Row  in  11  row of the traceback start cell (0..MAX/SIZE_ROW-1).
REQ-006 End_Col  in  2  column of the traceback start cell (0..SIZE_ROW-1).
REQ-007 P_In  in  D_WIDTH  path-code read data from the P SRAM.
REQ-008 P_Addr  out  A_WIDTH  P SRAM address.
REQ-009 P_En / P_Rw  out  1 each  P SRAM enable / write strobe; P_Rw is always 0 (read-only client).
REQ-010 Dir_Out  out  D_WIDTH  path code of the current beat.
REQ-011 Dir_Valid  out  1 / Dir_Ready  in  1  output beat handshake.
REQ-012 Len_Out  out  12  number of beats accepted in the current or last trace.
REQ-013 Done  out  1  one-cycle completion pulse; Err  out  1  trace-failed flag, held until next Go.

Function
REQ-014 Path codes: Start=0x08, Right=0x09 (predecessor is col-1), Down=0x0A (predecessor is row-1); any other value is illegal.
REQ-015 Cell address = row*SIZE_ROW + col, truncated to A_WIDTH bits.
REQ-016 States: IDLE, RD, WT, EMIT, FIN.
REQ-017 IDLE: on Go=1, latch End_Row/End_Col into Row/Col, clear Len_Out and Err, go to RD; otherwise stay in IDLE.
REQ-018 RD (1 cycle): P_En=1, P_Rw=0, P_Addr=Row*SIZE_ROW+Col; go to WT.
REQ-019 WT (1 cycle): P_En=0; P_In is valid in this cycle and is registered into P_Reg at its closing edge; go to EMIT.
REQ-020 EMIT, illegal code in P_Reg, or Right with Col=0, or Down with Row=0: set Err=1, assert no Dir_Valid, go to FIN.
REQ-021 EMIT, legal code: Dir_Valid=1 and Dir_Out=P_Reg, both held stable until Dir_Ready=1.
REQ-022 On a handshake (Dir_Valid and Dir_Ready both 1): Len_Out increments by 1, then:
 - Start goes to FIN;
 - Right decrements Col and goes to RD;
 - Down decrements Row and goes to RD.
REQ-023 No P read is issued while EMIT is stalled.
REQ-024 FIN (1 cycle): Done=1; go to IDLE.
REQ-025 Beats are emitted end-to-start; minimum 3 cycles per beat when Dir_Ready is held at 1.
REQ-026 Go outside IDLE is ignored.
REQ-027 Go asserted in the same cycle that FIN→IDLE occurs is ignored; Go must be seen in IDLE.
REQ-028 A legal trace has at most End_Row+End_Col+1 beats; Len_Out never wraps.

Reset
REQ-029 While Rst=0, asynchronously:
 - state returns to IDLE;
 - P_Addr, Dir_Out, P_Reg, Row, Col, Len_Out are all zero;
 - P_En, P_Rw, Dir_Valid, Done, Err are all 0.
REQ-030 Reset mid-trace abandons the trace with no further P reads or beats; the first Go after release starts a fresh trace.

Structure
REQ-031 Package path_pkg holds SIZE_ROW, MAX, D_WIDTH, A_WIDTH, the Start/Right/Down codes and the state encoding; it is shared with the shortest-path writer.
REQ-032 One combinational sub-module, path_step_decode, takes (code, Row, Col) and returns next Row, next Col, is_start and illegal.
REQ-033 All other logic is in one clocked process plus one next-state process.

Verification
REQ-034 End=(0,0), P[0]=0x08, Ready=1 → one P read at address 0; one beat 0x08; Len_Out=1; Done pulse; Err=0.
REQ-035 End=(1,2), P[6]=0x09, P[5]=0x0A, P[1]=0x09, P[0]=0x08 → read addresses 6,5,1,0; beats 09,0A,09,08; Len_Out=4; 12 cycles from RD to FIN.
REQ-036 Same grid as REQ-035, Ready=0 for 5 cycles on beat 2 → Dir_Out held at 0x0A, no P_En during the stall, final Len_Out=4.
REQ-037 End=(1,0), P[4]=0x09 → Err=1, Done pulse, zero beats, Len_Out=0.
REQ-038 End=(0,1), P[1]=0x00 → Err=1, no beat; also Go pulsed during EMIT → ignored.
REQ-039 Rst=0 asserted during WT of beat 2 → all outputs zero immediately; after release, Go with End=(0,0) completes normally.

Source files
------------

// File: rtl/path_pkg.sv
// path_pkg -- constants shared by the path traceback engine and the
// shortest-path writer that fills the P memory.
//   Grid geometry : SIZE_ROW, MAX, ROW_W, COL_W
//   Memory shape  : D_WIDTH, A_WIDTH
//   Path codes    : CODE_START, CODE_RIGHT, CODE_DOWN
//   FSM encoding  : state_t
package path_pkg;

   localparam int SIZE_ROW = 4;
   localparam int MAX      = 8192;
   localparam int D_WIDTH  = 8;
   localparam int A_WIDTH  = 13;
   localparam int ROW_W    = 11;
   localparam int COL_W    = 2;
   localparam int LEN_W    = 12;

   localparam logic [7:0] CODE_START = 8'h08;
   localparam logic [7:0] CODE_RIGHT = 8'h09;   // predecessor is col-1
   localparam logic [7:0] CODE_DOWN  = 8'h0A;   // predecessor is row-1

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WT   = 3'd2,
      ST_EMIT = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

endpackage

// File: rtl/path_step_decode.sv
// path_step_decode -- combinational decode of one path code.
//   i_code       : path code read from P
//   i_row/i_col  : coordinates of the cell the code belongs to
//   o_next_row/o_next_col : coordinates of the predecessor cell
//   o_is_start   : code marks the start of the path
//   o_illegal    : unknown code, or a step that would leave the grid
module path_step_decode #(
   parameter int D_WIDTH = path_pkg::D_WIDTH
) (
   input  logic [D_WIDTH-1:0]         i_code,
   input  logic [path_pkg::ROW_W-1:0] i_row,
   input  logic [path_pkg::COL_W-1:0] i_col,
   output logic [path_pkg::ROW_W-1:0] o_next_row,
   output logic [path_pkg::COL_W-1:0] o_next_col,
   output logic                       o_is_start,
   output logic                       o_illegal
);
   import path_pkg::*;

   // Decode the code into a predecessor step or an error.
   always_comb begin
      o_next_row = i_row;
      o_next_col = i_col;
      o_is_start = 1'b0;
      o_illegal  = 1'b0;
      if (i_code == D_WIDTH'(CODE_START)) begin
         o_is_start = 1'b1;
      end else if (i_code == D_WIDTH'(CODE_RIGHT)) begin
         if (i_col == '0) begin
            o_illegal = 1'b1;
         end else begin
            o_next_col = i_col - 2'd1;
         end
      end else if (i_code == D_WIDTH'(CODE_DOWN)) begin
         if (i_row == '0) begin
            o_illegal = 1'b1;
         end else begin
            o_next_row = i_row - 11'd1;
         end
      end else begin
         o_illegal = 1'b1;
      end
   end

endmodule

// File: rtl/path_trace.sv
// path_trace -- walks a shortest-path code map backwards from an end cell,
// reading one P SRAM cell per step and emitting each code as a beat.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_go                    : start pulse (honoured only in IDLE)
//   i_end_row, i_end_col    : traceback start cell
//   i_p_in                  : P SRAM read data (valid the cycle after o_p_en)
//   o_p_addr, o_p_en, o_p_rw: P SRAM read port (o_p_rw always 0)
//   o_dir_out, o_dir_valid, i_dir_ready : beat stream, valid/ready
//   o_len_out               : beats accepted in current / last trace
//   o_done, o_err           : completion pulse, sticky error flag
module path_trace #(
   parameter int SIZE_ROW = path_pkg::SIZE_ROW,
   parameter int MAX      = path_pkg::MAX,
   parameter int D_WIDTH  = path_pkg::D_WIDTH,
   parameter int A_WIDTH  = path_pkg::A_WIDTH
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_go,
   input  logic [10:0]        i_end_row,
   input  logic [1:0]         i_end_col,
   input  logic [D_WIDTH-1:0] i_p_in,
   output logic [A_WIDTH-1:0] o_p_addr,
   output logic               o_p_en,
   output logic               o_p_rw,
   output logic [D_WIDTH-1:0] o_dir_out,
   output logic               o_dir_valid,
   input  logic               i_dir_ready,
   output logic [11:0]        o_len_out,
   output logic               o_done,
   output logic               o_err
);
   import path_pkg::*;

   state_t             r_state, w_state_nxt;
   logic [10:0]        r_row, r_nrow, w_nrow;
   logic [1:0]         r_col, r_ncol, w_ncol;
   logic [D_WIDTH-1:0] r_p_reg;
   logic [A_WIDTH-1:0] r_p_addr;
   logic               r_p_en, r_dir_valid, r_done, r_err;
   logic [D_WIDTH-1:0] r_dir_out;
   logic [11:0]        r_len;
   logic               r_is_start, r_illegal;
   logic               w_is_start, w_illegal, w_hs;

   function automatic logic [A_WIDTH-1:0] f_cell_addr(input logic [10:0] row,
                                                      input logic [1:0]  col);
      logic [31:0] full;
      full = 32'(row) * 32'(SIZE_ROW) + 32'(col);
      return full[A_WIDTH-1:0];
   endfunction

   // The code is decoded straight off the SRAM bus during WT so that EMIT can
   // present a registered Dir_Valid in its first cycle (3 cycles per beat).
   path_step_decode #(.D_WIDTH(D_WIDTH)) u_decode (
      .i_code     (i_p_in),
      .i_row      (r_row),
      .i_col      (r_col),
      .o_next_row (w_nrow),
      .o_next_col (w_ncol),
      .o_is_start (w_is_start),
      .o_illegal  (w_illegal)
   );

   assign w_hs = r_dir_valid & i_dir_ready;

   // Next-state selection.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_go) w_state_nxt = ST_RD;
            else      w_state_nxt = ST_IDLE;
         end
         ST_RD:   w_state_nxt = ST_WT;
         ST_WT:   w_state_nxt = ST_EMIT;
         ST_EMIT: begin
            if (r_illegal)       w_state_nxt = ST_FIN;
            else if (!w_hs)      w_state_nxt = ST_EMIT;
            else if (r_is_start) w_state_nxt = ST_FIN;
            else                 w_state_nxt = ST_RD;
         end
         ST_FIN:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register, datapath and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_nrow      <= '0;
         r_ncol      <= '0;
         r_p_reg     <= '0;
         r_p_addr    <= '0;
         r_p_en      <= 1'b0;
         r_dir_out   <= '0;
         r_dir_valid <= 1'b0;
         r_len       <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_is_start  <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Enable and Done are high exactly for the RD and FIN cycles.
         r_p_en  <= (w_state_nxt == ST_RD);
         r_done  <= (w_state_nxt == ST_FIN);
         case (r_state)
            ST_IDLE: begin
               if (i_go) begin
                  r_row    <= i_end_row;
                  r_col    <= i_end_col;
                  r_len    <= '0;
                  r_err    <= 1'b0;
                  r_p_addr <= f_cell_addr(i_end_row, i_end_col);
               end
            end
            ST_WT: begin
               r_p_reg     <= i_p_in;
               r_nrow      <= w_nrow;
               r_ncol      <= w_ncol;
               r_is_start  <= w_is_start;
               r_illegal   <= w_illegal;
               r_dir_valid <= ~w_illegal;
               if (!w_illegal) r_dir_out <= i_p_in;
            end
            ST_EMIT: begin
               if (r_illegal) begin
                  r_err <= 1'b1;
               end else if (w_hs) begin
                  r_dir_valid <= 1'b0;
                  if (r_len != 12'hFFF) r_len <= r_len + 12'd1;
                  if (!r_is_start) begin
                     r_row    <= r_nrow;
                     r_col    <= r_ncol;
                     r_p_addr <= f_cell_addr(r_nrow, r_ncol);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_p_addr    = r_p_addr;
   assign o_p_en      = r_p_en;
   assign o_p_rw      = 1'b0;
   assign o_dir_out   = r_dir_out;
   assign o_dir_valid = r_dir_valid;
   assign o_len_out   = r_len;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_path_trace.sv
// tb_path_trace -- scoreboard bench for path_trace: expected P read
// addresses and beats are queued per trace and popped as the DUT produces them.
module tb_path_trace;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        go;
   logic [10:0] end_row;
   logic [1:0]  end_col;
   logic [7:0]  p_in = 8'h00;
   logic [12:0] p_addr;
   logic        p_en, p_rw;
   logic [7:0]  dir_out;
   logic        dir_valid;
   logic        ready;
   logic [11:0] len_out;
   logic        done, err;

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0]  mem [0:15];
   int unsigned exp_addr_q [$];
   logic [7:0]  exp_beat_q [$];

   always #5 clk = ~clk;

   path_trace dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_go        (go),
      .i_end_row   (end_row),
      .i_end_col   (end_col),
      .i_p_in      (p_in),
      .o_p_addr    (p_addr),
      .o_p_en      (p_en),
      .o_p_rw      (p_rw),
      .o_dir_out   (dir_out),
      .o_dir_valid (dir_valid),
      .i_dir_ready (ready),
      .o_len_out   (len_out),
      .o_done      (done),
      .o_err       (err)
   );

   // Synchronous-read SRAM model: data appears the cycle after the enable.
   always @(posedge clk) begin
      if (p_en) p_in <= mem[p_addr[3:0]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
   endtask

   task automatic load_grid();
      clear_mem();
      mem[6] = 8'h09; mem[5] = 8'h0A; mem[1] = 8'h09; mem[0] = 8'h08;
      exp_addr_q = '{6, 5, 1, 0};
      exp_beat_q = '{8'h09, 8'h0A, 8'h09, 8'h08};
   endtask

   task automatic run_trace(input int row, input int col, input int exp_len,
                            input int exp_err, input int exp_cycles,
                            input int stall_beat, input int stall_n,
                            input int go_at, input int rst_at);
      int cyc, rd_start, fin_cyc, beats, done_cnt, stall_left, tail;
      bit finished;
      @(negedge clk);
      end_row = 11'(row); end_col = 2'(col); go = 1'b1; ready = 1'b1;
      cyc = -1; rd_start = -1; fin_cyc = -1; beats = 0; done_cnt = 0;
      stall_left = stall_n; tail = -1; finished = 1'b0;
      while (!finished) begin
         @(posedge clk); #1;
         go = ((cyc + 1) == go_at);
         if (stall_beat > 0 && dir_valid && beats == stall_beat - 1 && stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
         end else begin
            ready = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (cyc == rst_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_p_addr", 32'(p_addr), 32'd0);
            check("rst_p_en", 32'(p_en), 32'd0);
            check("rst_dir_out", 32'(dir_out), 32'd0);
            check("rst_dir_valid", 32'(dir_valid), 32'd0);
            check("rst_len", 32'(len_out), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_reads_issued", 32'(exp_addr_q.size()), 32'd0);
            exp_beat_q.delete();
            finished = 1'b1;
         end else begin
            check("p_rw", 32'(p_rw), 32'd0);
            check("read_while_valid", 32'(p_en & dir_valid), 32'd0);
            if (p_en) begin
               if (rd_start < 0) rd_start = cyc;
               if (exp_addr_q.size() == 0) check("extra_read", 32'(p_addr), 32'hFFFF_FFFF);
               else check("rd_addr", 32'(p_addr), exp_addr_q.pop_front());
            end
            if (dir_valid && ready) begin
               beats++;
               if (exp_beat_q.size() == 0) check("extra_beat", 32'(dir_out), 32'hFFFF_FFFF);
               else check("beat", 32'(dir_out), 32'(exp_beat_q.pop_front()));
            end else if (dir_valid && exp_beat_q.size() > 0) begin
               check("stall_hold", 32'(dir_out), 32'(exp_beat_q[0]));
            end
            if (done) begin
               done_cnt++;
               fin_cyc = cyc;
               check("len_out", 32'(len_out), 32'(exp_len));
               check("err", 32'(err), 32'(exp_err));
               tail = 6;
            end else if (tail > 0) begin
               tail--;
            end
            if (tail == 0) finished = 1'b1;
            if (cyc >= 300) begin
               check("timeout", 32'd1, 32'd0);
               finished = 1'b1;
            end
         end
      end
      go = 1'b0;
      ready = 1'b1;
      if (rst_at < 0) begin
         check("done_pulses", 32'(done_cnt), 32'd1);
         check("reads_left", 32'(exp_addr_q.size()), 32'd0);
         check("beats_left", 32'(exp_beat_q.size()), 32'd0);
         check("err_held", 32'(err), 32'(exp_err));
         if (exp_cycles >= 0) check("rd_to_fin", 32'(fin_cyc - rd_start), 32'(exp_cycles));
      end
   endtask

   initial begin
      rst_n = 1'b0; go = 1'b0; ready = 1'b1; end_row = 11'd0; end_col = 2'd0;
      clear_mem();
      repeat (3) @(negedge clk);
      check("init_p_en", 32'(p_en), 32'd0);
      check("init_dir_valid", 32'(dir_valid), 32'd0);
      check("init_len", 32'(len_out), 32'd0);
      check("init_done_err", 32'({done, err}), 32'd0);
      rst_n = 1'b1;

      // Single-cell trace.
      clear_mem(); mem[0] = 8'h08;
      exp_addr_q = '{0}; exp_beat_q = '{8'h08};
      run_trace(0, 0, 1, 0, 3, 0, 0, -1, -1);

      // Four-beat trace at full rate.
      load_grid();
      run_trace(1, 2, 4, 0, 12, 0, 0, -1, -1);

      // Same trace with a 5-cycle stall on beat 2.
      load_grid();
      run_trace(1, 2, 4, 0, 17, 2, 5, -1, -1);

      // Right step out of column 0.
      clear_mem(); mem[4] = 8'h09;
      exp_addr_q = '{4};
      run_trace(1, 0, 0, 1, 3, 0, 0, -1, -1);

      // Illegal code, with Go pulsed during EMIT.
      clear_mem(); mem[1] = 8'h00;
      exp_addr_q = '{1};
      run_trace(0, 1, 0, 1, 3, 0, 0, 2, -1);

      // Down step out of row 0.
      clear_mem(); mem[2] = 8'h0A;
      exp_addr_q = '{2};
      run_trace(0, 2, 0, 1, 3, 0, 0, -1, -1);

      // Reset during WT of beat 2, then a fresh trace.
      load_grid();
      exp_addr_q = '{6, 5};
      run_trace(1, 2, 0, 0, -1, 0, 0, -1, 4);
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_p_en", 32'(p_en), 32'd0);
      end
      rst_n = 1'b1;
      clear_mem(); mem[0] = 8'h08;
      exp_addr_q = '{0}; exp_beat_q = '{8'h08};
      run_trace(0, 0, 1, 0, 3, 0, 0, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
